// File: rtl/issue_scoreboard_pkg.sv
// Shared definitions for the register-hazard scoreboard and the stages that
// need to see its drain state.
package issue_scoreboard_pkg;

  localparam int REG_COUNT = 32;
  localparam int REG_SIZE  = 5;

  typedef enum logic [1:0] {
    DRAIN_RUN  = 2'd0,
    DRAIN_WAIT = 2'd1,
    DRAIN_DONE = 2'd2
  } drain_state_e;

endpackage

// File: rtl/issue_scoreboard_sb_counter.sv
// Saturating up/down counter tracking in-flight writes to one register.
// Decrements that would go below zero are dropped and reported.
module sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_inc,
  input  logic             i_dec_k,
  input  logic             i_dec_w,
  output logic [CNT_W-1:0] o_cnt,
  output logic [CNT_W-1:0] o_cnt_next,
  output logic             o_zero,
  output logic             o_full,
  output logic             o_underflow
);
  import issue_scoreboard_pkg::*;

  localparam logic [CNT_W:0]   MAX_EXT  = {1'b0, {CNT_W{1'b1}}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W:0]   w_up;
  logic [CNT_W:0]   w_dn;
  logic [CNT_W:0]   w_diff;

  // One spare bit lets cnt+inc exceed max briefly when a same-cycle release
  // brings it back in range.
  always_comb begin
    w_up        = {1'b0, r_cnt} + {{CNT_W{1'b0}}, i_inc};
    w_dn        = {{CNT_W{1'b0}}, i_dec_k} + {{CNT_W{1'b0}}, i_dec_w};
    w_diff      = w_up - w_dn;
    o_cnt_next  = r_cnt;
    o_underflow = 1'b0;
    if (w_dn > w_up) begin
      o_cnt_next  = CNT_ZERO;
      o_underflow = 1'b1;
    end else if (w_diff > MAX_EXT) begin
      o_cnt_next = CNT_MAX;
    end else begin
      o_cnt_next = w_diff[CNT_W-1:0];
    end
  end

  // Counter state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= CNT_ZERO;
    end else begin
      r_cnt <= o_cnt_next;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_zero = (r_cnt == CNT_ZERO);
  assign o_full = (r_cnt == CNT_MAX);

endmodule

// File: rtl/issue_scoreboard.sv
// Decode-side hazard scoreboard: per-register pending-write counters, stall
// generation and a drain sequencer for serialising instructions.
module issue_scoreboard #(
  parameter int REG_COUNT = issue_scoreboard_pkg::REG_COUNT,
  parameter int REG_SIZE  = issue_scoreboard_pkg::REG_SIZE,
  parameter int CNT_W     = 2,
  parameter int PEND_W    = 7
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 validD,
  input  logic [REG_SIZE-1:0]  rs1D,
  input  logic [REG_SIZE-1:0]  rs2D,
  input  logic                 useRs1D,
  input  logic                 useRs2D,
  input  logic [REG_SIZE-1:0]  rdD,
  input  logic                 regWriteD,
  input  logic                 drainReqD,
  input  logic                 killE,
  input  logic [REG_SIZE-1:0]  killRdE,
  input  logic                 regWriteW,
  input  logic [REG_SIZE-1:0]  writeRegW,
  output logic                 stallD,
  output logic                 issueD,
  output logic [REG_COUNT-1:0] busyRegs,
  output logic [PEND_W-1:0]    pending,
  output logic                 drainDone,
  output logic                 errUnderflow
);
  import issue_scoreboard_pkg::*;

  localparam logic [REG_SIZE-1:0] X0       = {REG_SIZE{1'b0}};
  localparam logic [CNT_W-1:0]    CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(32'd1);
  localparam logic [PEND_W-1:0]   P_ZERO   = {PEND_W{1'b0}};

  logic                 w_inc;
  logic                 w_dec_k;
  logic                 w_dec_w;
  logic [CNT_W-1:0]     w_cnt      [REG_COUNT];
  logic [CNT_W-1:0]     w_cnt_next [REG_COUNT];
  logic [REG_COUNT-1:0] w_zero;
  logic [REG_COUNT-1:0] w_full;
  logic [REG_COUNT-1:0] w_uf;
  logic [PEND_W-1:0]    w_pending_next;
  logic                 w_eff1;
  logic                 w_eff2;
  logic                 w_src_haz;
  logic                 w_sat_haz;
  logic                 w_drain_stall;

  drain_state_e         r_state;
  logic [REG_COUNT-1:0] r_busy;
  logic [PEND_W-1:0]    r_pending;
  logic                 r_err;

  assign w_inc   = issueD & regWriteD & (rdD != X0);
  assign w_dec_k = killE & (killRdE != X0);
  assign w_dec_w = regWriteW & (writeRegW != X0);

  assign w_cnt[0]      = CNT_ZERO;
  assign w_cnt_next[0] = CNT_ZERO;
  assign w_zero[0]     = 1'b1;
  assign w_full[0]     = 1'b0;
  assign w_uf[0]       = 1'b0;

  generate
    for (genvar gi = 1; gi < REG_COUNT; gi++) begin : g_cnt
      logic w_hit_d;
      logic w_hit_k;
      logic w_hit_w;
      assign w_hit_d = w_inc   & (rdD       == REG_SIZE'(gi));
      assign w_hit_k = w_dec_k & (killRdE   == REG_SIZE'(gi));
      assign w_hit_w = w_dec_w & (writeRegW == REG_SIZE'(gi));
      sb_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk         (clk),
        .reset       (reset),
        .i_inc       (w_hit_d),
        .i_dec_k     (w_hit_k),
        .i_dec_w     (w_hit_w),
        .o_cnt       (w_cnt[gi]),
        .o_cnt_next  (w_cnt_next[gi]),
        .o_zero      (w_zero[gi]),
        .o_full      (w_full[gi]),
        .o_underflow (w_uf[gi])
      );
    end
  endgenerate

  // Writeback lands before decode reads, so a W release of the last pending
  // write clears the hazard this cycle; a kill release does not.
  always_comb begin
    w_eff1 = ~w_zero[rs1D] & ~(w_dec_w & (writeRegW == rs1D) & (w_cnt[rs1D] == CNT_ONE));
    w_eff2 = ~w_zero[rs2D] & ~(w_dec_w & (writeRegW == rs2D) & (w_cnt[rs2D] == CNT_ONE));
    w_src_haz = (useRs1D & (rs1D != X0) & w_eff1) |
                (useRs2D & (rs2D != X0) & w_eff2);
    w_sat_haz = regWriteD & (rdD != X0) & w_full[rdD] &
                ~(w_dec_w & (writeRegW == rdD));
    w_drain_stall = ((r_state == DRAIN_RUN) & drainReqD) | (r_state == DRAIN_WAIT);
    stallD    = validD & (w_src_haz | w_sat_haz | w_drain_stall);
    issueD    = validD & ~stallD;
    drainDone = (r_state == DRAIN_DONE) & issueD;
  end

  // Total in-flight writes after this edge.
  always_comb begin
    w_pending_next = P_ZERO;
    for (int i = 0; i < REG_COUNT; i++) begin
      w_pending_next = w_pending_next + PEND_W'(w_cnt_next[i]);
    end
  end

  // Drain sequencer; a flushed decode slot abandons the drain silently.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= DRAIN_RUN;
    end else begin
      case (r_state)
        DRAIN_RUN: begin
          if (validD & drainReqD) begin
            r_state <= (w_pending_next == P_ZERO) ? DRAIN_DONE : DRAIN_WAIT;
          end else begin
            r_state <= DRAIN_RUN;
          end
        end
        DRAIN_WAIT: begin
          if (!validD) begin
            r_state <= DRAIN_RUN;
          end else if (w_pending_next == P_ZERO) begin
            r_state <= DRAIN_DONE;
          end else begin
            r_state <= DRAIN_WAIT;
          end
        end
        DRAIN_DONE: begin
          if (!validD || issueD) begin
            r_state <= DRAIN_RUN;
          end else begin
            r_state <= DRAIN_DONE;
          end
        end
        default: r_state <= DRAIN_RUN;
      endcase
    end
  end

  // Registered status: busy map, pending total, sticky underflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy    <= {REG_COUNT{1'b0}};
      r_pending <= P_ZERO;
      r_err     <= 1'b0;
    end else begin
      for (int i = 0; i < REG_COUNT; i++) begin
        r_busy[i] <= (w_cnt_next[i] != CNT_ZERO);
      end
      r_pending <= w_pending_next;
      r_err     <= r_err | (|w_uf);
    end
  end

  assign busyRegs     = r_busy;
  assign pending      = r_pending;
  assign errUnderflow = r_err;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench: each cycle's expected outputs are queued by the stimulus
// and compared by an independent monitor on the falling edge.
module tb_issue_scoreboard;

  logic        clk;
  logic        reset;
  logic        validD, useRs1D, useRs2D, regWriteD, drainReqD, killE, regWriteW;
  logic [4:0]  rs1D, rs2D, rdD, killRdE, writeRegW;
  logic        stallD, issueD, drainDone, errUnderflow;
  logic [31:0] busyRegs;
  logic [6:0]  pending;

  int checks;
  int errors;

  typedef struct {
    string       nm;
    logic [5:0]  mask;
    logic        s;
    logic        i;
    logic        d;
    logic [31:0] b;
    logic [6:0]  p;
    logic        e;
  } exp_t;

  exp_t exp_q[$];

  localparam logic [5:0] M_ALL = 6'h3F;

  issue_scoreboard dut (
    .clk(clk), .reset(reset), .validD(validD), .rs1D(rs1D), .rs2D(rs2D),
    .useRs1D(useRs1D), .useRs2D(useRs2D), .rdD(rdD), .regWriteD(regWriteD),
    .drainReqD(drainReqD), .killE(killE), .killRdE(killRdE),
    .regWriteW(regWriteW), .writeRegW(writeRegW), .stallD(stallD),
    .issueD(issueD), .busyRegs(busyRegs), .pending(pending),
    .drainDone(drainDone), .errUnderflow(errUnderflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s.%s actual=%0h expected=%0h", nm, fld, act, expv);
    end
  endtask

  // Monitor: pops one expectation per cycle and compares.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      if (e.mask[0]) chk(e.nm, "stallD",       {31'd0, stallD},       {31'd0, e.s});
      if (e.mask[1]) chk(e.nm, "issueD",       {31'd0, issueD},       {31'd0, e.i});
      if (e.mask[2]) chk(e.nm, "drainDone",    {31'd0, drainDone},    {31'd0, e.d});
      if (e.mask[3]) chk(e.nm, "busyRegs",     busyRegs,              e.b);
      if (e.mask[4]) chk(e.nm, "pending",      {25'd0, pending},      {25'd0, e.p});
      if (e.mask[5]) chk(e.nm, "errUnderflow", {31'd0, errUnderflow}, {31'd0, e.e});
    end
  end

  task automatic clr();
    validD = 1'b0; useRs1D = 1'b0; useRs2D = 1'b0; regWriteD = 1'b0;
    drainReqD = 1'b0; killE = 1'b0; regWriteW = 1'b0;
    rs1D = 5'd0; rs2D = 5'd0; rdD = 5'd0; killRdE = 5'd0; writeRegW = 5'd0;
  endtask

  task automatic step(input string nm, input logic [5:0] m, input logic s, input logic i,
                      input logic d, input logic [31:0] b, input logic [6:0] p, input logic e);
    exp_t x;
    x.nm = nm; x.mask = m; x.s = s; x.i = i; x.d = d; x.b = b; x.p = p; x.e = e;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] rd);
    clr(); validD = 1'b1; regWriteD = 1'b1; rdD = rd;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clr();
    reset = 1'b0;
    @(posedge clk);
    #1;
    step("reset", M_ALL, 1'b0, 1'b0, 1'b0, 32'h0, 7'd0, 1'b0);
    reset = 1'b1;

    // RAW on x5, released by writeback
    wr(5'd5);                     step("raw_issue", M_ALL, 1'b0, 1'b1, 1'b0, 32'h0, 7'd0, 1'b0);
    clr(); validD = 1'b1; useRs1D = 1'b1; rs1D = 5'd5;
                                  step("raw_stall", M_ALL, 1'b1, 1'b0, 1'b0, 32'h20, 7'd1, 1'b0);
    regWriteW = 1'b1; writeRegW = 5'd5;
                                  step("raw_wb_clear", M_ALL, 1'b0, 1'b1, 1'b0, 32'h20, 7'd1, 1'b0);
    clr();                        step("raw_busy_gone", M_ALL, 1'b0, 1'b0, 1'b0, 32'h0, 7'd0, 1'b0);

    // Saturation on x7
    wr(5'd7);                     step("sat_w1", M_ALL, 1'b0, 1'b1, 1'b0, 32'h0, 7'd0, 1'b0);
                                  step("sat_w2", M_ALL, 1'b0, 1'b1, 1'b0, 32'h80, 7'd1, 1'b0);
                                  step("sat_w3", M_ALL, 1'b0, 1'b1, 1'b0, 32'h80, 7'd2, 1'b0);
                                  step("sat_w4_stall", M_ALL, 1'b1, 1'b0, 1'b0, 32'h80, 7'd3, 1'b0);
    regWriteW = 1'b1; writeRegW = 5'd7;
                                  step("sat_w4_wb", M_ALL, 1'b0, 1'b1, 1'b0, 32'h80, 7'd3, 1'b0);
    wr(5'd7);                     step("sat_still3", M_ALL, 1'b1, 1'b0, 1'b0, 32'h80, 7'd3, 1'b0);
    clr(); regWriteW = 1'b1; writeRegW = 5'd7;
                                  step("sat_rel1", M_ALL, 1'b0, 1'b0, 1'b0, 32'h80, 7'd3, 1'b0);
                                  step("sat_rel2", M_ALL, 1'b0, 1'b0, 1'b0, 32'h80, 7'd2, 1'b0);
                                  step("sat_rel3", M_ALL, 1'b0, 1'b0, 1'b0, 32'h80, 7'd1, 1'b0);

    // Simultaneous inc/kill/wb on x9
    wr(5'd9);                     step("tri_pre", M_ALL, 1'b0, 1'b1, 1'b0, 32'h0, 7'd0, 1'b0);
    killE = 1'b1; killRdE = 5'd9; regWriteW = 1'b1; writeRegW = 5'd9;
                                  step("tri_same", M_ALL, 1'b0, 1'b1, 1'b0, 32'h200, 7'd1, 1'b0);

    // x0 handling and underflow
    clr(); validD = 1'b1; regWriteD = 1'b1; rdD = 5'd0; useRs1D = 1'b1; rs1D = 5'd0;
    regWriteW = 1'b1; writeRegW = 5'd0;
                                  step("x0_nostall", M_ALL, 1'b0, 1'b1, 1'b0, 32'h0, 7'd0, 1'b0);
    clr(); regWriteW = 1'b1; writeRegW = 5'd3;
                                  step("x0_noerr", M_ALL, 1'b0, 1'b0, 1'b0, 32'h0, 7'd0, 1'b0);
    clr();                        step("uf_sticky", M_ALL, 1'b0, 1'b0, 1'b0, 32'h0, 7'd0, 1'b1);

    // Drain with two pending writes
    wr(5'd10);                    step("dr_w10", M_ALL, 1'b0, 1'b1, 1'b0, 32'h0, 7'd0, 1'b1);
    wr(5'd11);                    step("dr_w11", M_ALL, 1'b0, 1'b1, 1'b0, 32'h400, 7'd1, 1'b1);
    clr(); validD = 1'b1; drainReqD = 1'b1;
                                  step("dr_req", M_ALL, 1'b1, 1'b0, 1'b0, 32'hC00, 7'd2, 1'b1);
    regWriteW = 1'b1; writeRegW = 5'd10;
                                  step("dr_wait1", M_ALL, 1'b1, 1'b0, 1'b0, 32'hC00, 7'd2, 1'b1);
    writeRegW = 5'd11;            step("dr_wait2", M_ALL, 1'b1, 1'b0, 1'b0, 32'h800, 7'd1, 1'b1);
    regWriteW = 1'b0;             step("dr_done", M_ALL, 1'b0, 1'b1, 1'b1, 32'h0, 7'd0, 1'b1);
                                  step("dr_empty_req", M_ALL, 1'b1, 1'b0, 1'b0, 32'h0, 7'd0, 1'b1);
                                  step("dr_empty_done", M_ALL, 1'b0, 1'b1, 1'b1, 32'h0, 7'd0, 1'b1);

    // Reset while draining with four pending
    wr(5'd12);                    step("rs_w12", 6'h13, 1'b0, 1'b1, 1'b0, 32'h0, 7'd0, 1'b1);
    wr(5'd13);                    step("rs_w13", 6'h13, 1'b0, 1'b1, 1'b0, 32'h0, 7'd1, 1'b1);
    wr(5'd14);                    step("rs_w14", 6'h13, 1'b0, 1'b1, 1'b0, 32'h0, 7'd2, 1'b1);
    wr(5'd15);                    step("rs_w15", 6'h13, 1'b0, 1'b1, 1'b0, 32'h0, 7'd3, 1'b1);
    clr(); validD = 1'b1; drainReqD = 1'b1;
                                  step("rs_req", M_ALL, 1'b1, 1'b0, 1'b0, 32'hF000, 7'd4, 1'b1);
                                  step("rs_wait", M_ALL, 1'b1, 1'b0, 1'b0, 32'hF000, 7'd4, 1'b1);
    reset = 1'b0;
    clr(); regWriteW = 1'b1; writeRegW = 5'd12; killE = 1'b1; killRdE = 5'd13;
                                  step("rs_async", M_ALL, 1'b0, 1'b0, 1'b0, 32'h0, 7'd0, 1'b0);
                                  step("rs_hold", M_ALL, 1'b0, 1'b0, 1'b0, 32'h0, 7'd0, 1'b0);
    reset = 1'b1;
    clr(); validD = 1'b1; useRs1D = 1'b1; rs1D = 5'd12; regWriteD = 1'b1; rdD = 5'd20;
                                  step("rs_first", M_ALL, 1'b0, 1'b1, 1'b0, 32'h0, 7'd0, 1'b0);
    clr();                        step("rs_after", M_ALL, 1'b0, 1'b0, 1'b0, 32'h100000, 7'd1, 1'b0);

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain_queue actual=%0d expected=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/issue_scoreboard.md
# issue_scoreboard

Register-hazard scoreboard and issue controller for the pipelined core. It counts in-flight writes per architectural register and stalls the decode stage when a source register is still pending. It also drains the pipeline for serialising (SYSTEM-opcode) instructions. It sits beside the decode stage and takes release events from the exec stage (squash on taken branch) and the writeback stage.

## Interface
Parameters:
- REG_COUNT, 32, architectural registers (x0 included, never tracked)
- REG_SIZE, 5, register index width
- CNT_W, 2, per-register in-flight counter width (max 3 pending writes)
- PEND_W, 7, total-pending counter width; must hold REG_COUNT*(2^CNT_W-1)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- validD  in  1  decode holds a valid instruction
- rs1D, rs2D  in  REG_SIZE  source indices
- useRs1D, useRs2D  in  1  source actually read
- rdD  in  REG_SIZE  destination index
- regWriteD  in  1  instruction writes rdD
- drainReqD  in  1  decode instruction is serialising
- killE  in  1  exec instruction squashed; releases its pending write
- killRdE  in  REG_SIZE  destination of squashed instruction
- regWriteW  in  1  writeback commits a register write
- writeRegW  in  REG_SIZE  writeback destination
- stallD  out  1  hold fetch/decode this cycle
- issueD  out  1  validD & ~stallD
- busyRegs  out  REG_COUNT  bit i = counter i non-zero (bit 0 always 0)
- pending  out  PEND_W  total in-flight writes
- drainDone  out  1  one-cycle pulse: serialising instruction issues
- errUnderflow  out  1  sticky: release hit a zero counter

## Operation
- Per-register counter cnt[i], i=1..REG_COUNT-1; cnt[0] is constant 0.
- Events per cycle, applied at posedge: inc = issueD & regWriteD & rdD!=0; decK = killE & killRdE!=0; decW = regWriteW & writeRegW!=0.
- Any subset may target the same register in one cycle. Next value = cnt + inc - decK - decW.
- A decrement of a zero counter is dropped, not wrapped. It sets errUnderflow, which is cleared only by reset.
- Effective count: eff[i] = cnt[i] - decW(i). The regfile writes on negedge, so decode reads the new value in the same cycle, and a writeback release clears the hazard that cycle. A kill release does not clear it.
- Source hazard: (useRs1D & rs1D!=0 & eff[rs1D]!=0) | (useRs2D & rs2D!=0 & eff[rs2D]!=0).
- Saturation hazard: regWriteD & rdD!=0 & cnt[rdD]==max. The instruction stalls rather than overflowing the counter.
- pending tracks the sum of all counters and updates with the same net delta.
- Drain FSM, states RUN, DRAIN, DONE:
  - RUN: if validD & drainReqD, stall. Go to DONE if pending_next==0, else go to DRAIN.
  - DRAIN: stall. Go to DONE when pending_next==0.
  - DONE: no drain stall; drainDone=1; the instruction issues if there is no source hazard; then return to RUN.
  - If validD drops in DRAIN or DONE (decode flushed), return to RUN without a drainDone pulse.
- stallD = validD & (source hazard | saturation hazard | drain stall).

## Timing
- Reset values: all counters 0, pending 0, FSM RUN, errUnderflow 0, busyRegs 0, drainDone 0, stallD 0.
- Reset mid-operation clears all state immediately, regardless of in-flight events.
- stallD and issueD are combinational from state plus current inputs. There is no registered latency.
- busyRegs, pending and errUnderflow are registered: they reflect events from the previous edge.
- Read-after-write latency: an instruction that issues at cycle t makes its rd busy from t+1 until the cycle its writeback release is seen, inclusive of that cycle's hazard clearing.
- Drain with nothing pending costs exactly one stall cycle. drainDone is asserted in the cycle after the last release.

## Structure
- Shared package holds REG_COUNT, REG_SIZE and the drain-state enum (DRAIN_RUN, DRAIN_WAIT, DRAIN_DONE). The enum is shared so the hazard/flush logic in the exec stage can reference it.
- One sub-module, sb_counter: a CNT_W saturating up/down counter with inc, decK and decW inputs, and zero, full and underflow outputs. Instantiate it REG_COUNT-1 times via generate.

## Test plan
- Issue add x5 (regWriteD, rd=5), then next cycle decode reads rs1=5 -> stallD=1. When writeback releases x5, stallD=0 in the same cycle and busyRegs[5]=0 the next cycle.
- Issue three writes to x7 back-to-back, then a fourth -> fourth stalls (cnt=3). Release one in W -> fourth issues the same cycle and cnt stays 3.
- Same cycle: issue to x9, killE with x9, writeback with x9, cnt[9]=1 beforehand -> cnt[9]=0 and pending drops by 1.
- rdD=0 or rs1D=0 -> no counter change, never stalls; writeback with writeRegW=0 leaves errUnderflow=0. Release of x3 with cnt 0 -> errUnderflow=1, cnt stays 0.
- drainReqD with pending=2 -> stallD held until both releases. drainDone pulses one cycle, the instruction issues, and the FSM returns to RUN.
- Assert reset while pending=4 and the FSM is in DRAIN -> all outputs at reset values immediately; after release, the first instruction issues with no stall.
